clk_divider_multi: RTL and testbench

//   Multi-channel programmable clock divider for the LS013B7DH01 driver. It derives NUM_CH

---
 rtl/clk_divider_multi_if.sv | 28 ++
 rtl/clk_divider_multi.sv | 139 +++++++++++++
 tb/tb_clk_divider_multi.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/clk_divider_multi_if.sv
// rtl/clk_divider_multi_if.sv - config request port of the multi-channel clock divider
// Carries one divisor update per transfer; a transfer happens on a clock edge
// where cfg_valid and cfg_ready are both high.
interface clk_divider_multi_if #(
  parameter int NUM_CH    = 2,
  parameter int CNT_WIDTH = 16
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [CH_W-1:0]      cfg_ch;
  logic [CNT_WIDTH-1:0] cfg_div;

  modport master (
    output cfg_valid,
    output cfg_ch,
    output cfg_div,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_ch,
    input  cfg_div,
    output cfg_ready
  );
endinterface

// File: rtl/clk_divider_multi.sv
// rtl/clk_divider_multi.sv - multi-channel programmable clock divider with rise/fall strobes
// Each channel counts a period k = 0..D-1 and drives clk_out high for k >= floor(D/2),
// so odd divisors put the extra cycle in the high phase. New divisors wait in a
// one-entry pending slot and only take effect at a period boundary, on stop/start,
// or on sync, so a period is never cut short or stretched mid-flight.
module clk_divider_multi #(
  parameter int NUM_CH      = 2,
  parameter int CNT_WIDTH   = 16,
  parameter int DEFAULT_DIV = 12
) (
  input  logic              clk_12mhz,
  input  logic              rst,
  clk_divider_multi_if.slave cfg,
  input  logic              sync,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] rise_stb,
  output logic [NUM_CH-1:0] fall_stb
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_WIDTH-1:0] DIV_RST = CNT_WIDTH'(DEFAULT_DIV);
  localparam logic [CNT_WIDTH-1:0] DIV_MIN = CNT_WIDTH'(2);
  localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);

  // registered per-channel state
  logic [CNT_WIDTH-1:0] div_q      [NUM_CH];
  logic [CNT_WIDTH-1:0] pend_div_q [NUM_CH];
  logic [CNT_WIDTH-1:0] cnt_q      [NUM_CH];
  logic [NUM_CH-1:0]    pend_q;
  logic [NUM_CH-1:0]    run_q;

  // next-state values
  logic [CNT_WIDTH-1:0] div_n      [NUM_CH];
  logic [CNT_WIDTH-1:0] pend_div_n [NUM_CH];
  logic [CNT_WIDTH-1:0] cnt_n      [NUM_CH];
  logic [CNT_WIDTH-1:0] half_n     [NUM_CH];
  logic [NUM_CH-1:0]    pend_n;
  logic [NUM_CH-1:0]    run_n;
  logic [NUM_CH-1:0]    clk_n;
  logic [NUM_CH-1:0]    rise_n;
  logic [NUM_CH-1:0]    fall_n;

  // per-channel decode
  logic [NUM_CH-1:0]    accept;
  logic [NUM_CH-1:0]    wrap;
  logic [NUM_CH-1:0]    restart;
  logic [NUM_CH-1:0]    apply;
  logic [CNT_WIDTH-1:0] cfg_div_c;

  // Divisors below 2 cannot form a low and a high phase, so they are raised to 2.
  assign cfg_div_c = (cfg.cfg_div < DIV_MIN) ? DIV_MIN : cfg.cfg_div;

  // Ready reflects the pending slot of the addressed channel; unused channel codes
  // are accepted and dropped so a master can never stall on them.
  always_comb begin
    cfg.cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg.cfg_ch == CH_W'(i)) begin
        cfg.cfg_ready = !pend_q[i];
      end
    end
  end

  // Transfer decode: only the addressed channel with a free pending slot takes the value.
  always_comb begin
    accept = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      accept[i] = cfg.cfg_valid && (cfg.cfg_ch == CH_W'(i)) && !pend_q[i];
    end
  end

  // Period counter, divisor apply and output decode for every channel.
  always_comb begin
    wrap    = '0;
    restart = '0;
    apply   = '0;
    pend_n  = '0;
    run_n   = '0;
    clk_n   = '0;
    rise_n  = '0;
    fall_n  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wrap[i]    = run_q[i] && (cnt_q[i] == (div_q[i] - ONE));
      // A running channel re-enters k=0 at its natural wrap or on sync.
      restart[i] = run_q[i] && ch_en[i] && (wrap[i] || sync);
      // Pending divisors land only where a fresh period starts or the channel is idle.
      apply[i]   = pend_q[i] && (!ch_en[i] || !run_q[i] || wrap[i] || sync);

      div_n[i]      = apply[i] ? pend_div_q[i] : div_q[i];
      pend_n[i]     = accept[i] || (pend_q[i] && !apply[i]);
      pend_div_n[i] = accept[i] ? cfg_div_c : pend_div_q[i];
      half_n[i]     = div_n[i] >> 1;

      if (!ch_en[i]) begin
        run_n[i] = 1'b0;
        cnt_n[i] = '0;
      end else if (!run_q[i] || restart[i]) begin
        run_n[i] = 1'b1;
        cnt_n[i] = '0;
      end else begin
        run_n[i] = 1'b1;
        cnt_n[i] = cnt_q[i] + ONE;
      end

      clk_n[i]  = ch_en[i] && (cnt_n[i] >= half_n[i]);
      rise_n[i] = ch_en[i] && (cnt_n[i] == half_n[i]);
      // A fall is only reported when the period restart ends a visible high phase;
      // a fresh start or a stop never produces one.
      fall_n[i] = restart[i] && clk_out[i];
    end
  end

  // State and registered outputs; reset overrides every other input.
  always_ff @(posedge clk_12mhz) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i]      <= DIV_RST;
        pend_div_q[i] <= DIV_RST;
        cnt_q[i]      <= '0;
      end
      pend_q   <= '0;
      run_q    <= '0;
      clk_out  <= '0;
      rise_stb <= '0;
      fall_stb <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i]      <= div_n[i];
        pend_div_q[i] <= pend_div_n[i];
        cnt_q[i]      <= cnt_n[i];
      end
      pend_q   <= pend_n;
      run_q    <= run_n;
      clk_out  <= clk_n;
      rise_stb <= rise_n;
      fall_stb <= fall_n;
    end
  end
endmodule

// File: tb/tb_clk_divider_multi.sv
// tb/tb_clk_divider_multi.sv - scoreboard bench for clk_divider_multi
module tb_clk_divider_multi;
  logic       clk_12mhz = 1'b0;
  logic       rst       = 1'b1;
  logic       sync      = 1'b0;
  logic [1:0] ch_en     = 2'b00;
  logic [1:0] clk_out;
  logic [1:0] rise_stb;
  logic [1:0] fall_stb;

  clk_divider_multi_if #(.NUM_CH(2), .CNT_WIDTH(16)) cfg_if ();

  clk_divider_multi #(
    .NUM_CH(2),
    .CNT_WIDTH(16),
    .DEFAULT_DIV(12)
  ) dut (
    .clk_12mhz(clk_12mhz),
    .rst(rst),
    .cfg(cfg_if),
    .sync(sync),
    .ch_en(ch_en),
    .clk_out(clk_out),
    .rise_stb(rise_stb),
    .fall_stb(fall_stb)
  );

  always #5 clk_12mhz = ~clk_12mhz;

  int cyc = 0;
  always @(posedge clk_12mhz) cyc <= cyc + 1;

  int total  = 0;
  int passed = 0;
  int base   = 0;
  int exp_q[$];

  task automatic chk(input string name, input int act, input int exp_v);
    total++;
    if (act == exp_v) passed++;
    else $display("FAIL %s at cyc %0d: got %0d, expected %0d", name, cyc, act, exp_v);
  endtask

  // strobe event code: absolute cycle, channel, kind (0 rise, 1 fall)
  function automatic int ev(input int c, input int ch, input int kind);
    return c * 4 + ch * 2 + kind;
  endfunction

  task automatic push_ev(input int n, input int ch, input int kind);
    exp_q.push_back(ev(base + n, ch, kind));
  endtask

  // monitor: every strobe the DUT emits is matched against the next expected event
  initial begin
    forever begin
      @(negedge clk_12mhz);
      for (int ch = 0; ch < 2; ch++) begin
        for (int kind = 0; kind < 2; kind++) begin
          if ((kind == 0) ? rise_stb[ch] : fall_stb[ch]) begin
            if (exp_q.size() == 0)
              chk($sformatf("unexpected_evt_ch%0d_kind%0d", ch, kind), ev(cyc, ch, kind), -1);
            else
              chk($sformatf("evt_ch%0d_kind%0d", ch, kind), ev(cyc, ch, kind), exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch    = 1'b0;
    cfg_if.cfg_div   = 16'd0;

    // reset state
    repeat (3) @(posedge clk_12mhz);
    @(negedge clk_12mhz);
    chk("rst_clk_out", int'(clk_out), 0);
    chk("rst_rise", int'(rise_stb), 0);
    chk("rst_fall", int'(fall_stb), 0);
    chk("rst_ready_ch0", int'(cfg_if.cfg_ready), 1);
    cfg_if.cfg_ch = 1'b1;
    #1;
    chk("rst_ready_ch1", int'(cfg_if.cfg_ready), 1);
    cfg_if.cfg_ch = 1'b0;
    @(posedge clk_12mhz); #1;
    rst = 1'b0;

    // default D=12 on ch0, stop while high, restart with a full low phase
    for (int n = -1; n <= 43; n++) begin
      @(posedge clk_12mhz); #1;
      if (n == -1) begin
        base = cyc - n;
        push_ev(6, 0, 0); push_ev(12, 0, 1); push_ev(18, 0, 0);
        push_ev(24, 0, 1); push_ev(30, 0, 0); push_ev(41, 0, 0);
      end
      case (n)
        -1: ch_en = 2'b01;
        32: ch_en = 2'b00;
        34: ch_en = 2'b01;
        42: ch_en = 2'b00;
        default: ;
      endcase
      @(negedge clk_12mhz);
      if (n >= 0 && n <= 31) chk("p1_level", int'(clk_out[0]), ((n % 12) >= 6) ? 1 : 0);
      else if (n == 32 || n == 41 || n == 42) chk("p1_level_hi", int'(clk_out[0]), 1);
      else if (n >= 33) chk("p1_level_lo", int'(clk_out[0]), 0);
    end

    // ch1: D=5, then clamped 0 and 1 both giving period 2
    for (int n = -2; n <= 31; n++) begin
      @(posedge clk_12mhz); #1;
      if (n == -2) begin
        base = cyc - n;
        push_ev(2, 1, 0);  push_ev(5, 1, 1);  push_ev(7, 1, 0);  push_ev(10, 1, 1);
        push_ev(12, 1, 0); push_ev(17, 1, 0); push_ev(18, 1, 1); push_ev(19, 1, 0);
        push_ev(20, 1, 1); push_ev(21, 1, 0); push_ev(22, 1, 1); push_ev(26, 1, 0);
        push_ev(27, 1, 1); push_ev(28, 1, 0); push_ev(29, 1, 1); push_ev(30, 1, 0);
      end
      case (n)
        -2: begin cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ch = 1'b1; cfg_if.cfg_div = 16'd5; end
        -1: begin cfg_if.cfg_valid = 1'b0; ch_en = 2'b10; end
        13: ch_en = 2'b00;
        14: begin cfg_if.cfg_valid = 1'b1; cfg_if.cfg_div = 16'd0; end
        15: begin cfg_if.cfg_valid = 1'b0; ch_en = 2'b10; end
        22: ch_en = 2'b00;
        23: begin cfg_if.cfg_valid = 1'b1; cfg_if.cfg_div = 16'd1; end
        24: begin cfg_if.cfg_valid = 1'b0; ch_en = 2'b10; end
        30: ch_en = 2'b00;
        default: ;
      endcase
      @(negedge clk_12mhz);
      if (n == -2 || n == 0 || n == 16) chk("p2_ready_hi", int'(cfg_if.cfg_ready), 1);
      if (n == -1 || n == 15) chk("p2_ready_lo", int'(cfg_if.cfg_ready), 0);
      if (n >= 0 && n <= 13) chk("p2_level_d5", int'(clk_out[1]), ((n % 5) >= 2) ? 1 : 0);
      else if (n >= 16 && n <= 22) chk("p2_level_d0", int'(clk_out[1]), (n - 16) % 2);
      else if (n >= 25 && n <= 30) chk("p2_level_d1", int'(clk_out[1]), (n - 25) % 2);
      else if (n == 14 || n == 23 || n == 31) chk("p2_level_off", int'(clk_out[1]), 0);
    end
    cfg_if.cfg_ch = 1'b0;

    // ch0 D=12, reprogram to 4 at k=3, stalled second request, ch1 accepted meanwhile
    for (int n = -1; n <= 31; n++) begin
      @(posedge clk_12mhz); #1;
      if (n == -1) begin
        base = cyc - n;
        push_ev(6, 0, 0);  push_ev(12, 0, 1); push_ev(14, 0, 0); push_ev(16, 0, 1);
        push_ev(19, 0, 0); push_ev(22, 0, 1); push_ev(25, 0, 0); push_ev(28, 0, 1);
      end
      case (n)
        -1: ch_en = 2'b01;
        3:  begin cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ch = 1'b0; cfg_if.cfg_div = 16'd4; end
        4:  cfg_if.cfg_div = 16'd6;
        5:  begin cfg_if.cfg_ch = 1'b1; cfg_if.cfg_div = 16'd8; end
        6:  begin cfg_if.cfg_ch = 1'b0; cfg_if.cfg_div = 16'd6; end
        13: cfg_if.cfg_valid = 1'b0;
        29: ch_en = 2'b00;
        30: begin cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ch = 1'b0; cfg_if.cfg_div = 16'd12; end
        31: cfg_if.cfg_valid = 1'b0;
        default: ;
      endcase
      @(negedge clk_12mhz);
      if (n == 3 || n == 5 || n == 12 || n == 16 || n == 30)
        chk("p3_ready_hi", int'(cfg_if.cfg_ready), 1);
      if (n == 4 || n == 6 || n == 11 || n == 13 || n == 15)
        chk("p3_ready_lo", int'(cfg_if.cfg_ready), 0);
      if (n >= 0)
        chk("p3_level", int'(clk_out[0]),
            ((n >= 6 && n <= 11) || (n >= 14 && n <= 15) ||
             (n >= 19 && n <= 21) || (n >= 25 && n <= 27)) ? 1 : 0);
    end

    // ch0 D=12 and ch1 D=8 out of phase, sync, then reset with a pending config
    for (int n = -1; n <= 48; n++) begin
      @(posedge clk_12mhz); #1;
      if (n == -1) begin
        base = cyc - n;
        push_ev(6, 0, 0);  push_ev(7, 1, 0);  push_ev(11, 1, 1); push_ev(12, 0, 1);
        push_ev(15, 1, 0); push_ev(17, 1, 1); push_ev(21, 1, 0); push_ev(23, 0, 0);
        push_ev(25, 1, 1); push_ev(29, 0, 1); push_ev(29, 1, 0); push_ev(33, 1, 1);
        push_ev(41, 0, 0); push_ev(47, 0, 1);
      end
      case (n)
        -1: ch_en = 2'b01;
        2:  ch_en = 2'b11;
        16: sync = 1'b1;
        17: sync = 1'b0;
        31: begin cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ch = 1'b0; cfg_if.cfg_div = 16'd4; end
        32: cfg_if.cfg_valid = 1'b0;
        33: rst = 1'b1;
        34: begin rst = 1'b0; ch_en = 2'b01; end
        48: ch_en = 2'b00;
        default: ;
      endcase
      @(negedge clk_12mhz);
      case (n)
        16: chk("p4_pre_sync", int'(clk_out), 2);
        17: begin
          chk("p4_sync_clk", int'(clk_out), 0);
          chk("p4_sync_rise", int'(rise_stb), 0);
        end
        22: chk("p4_aligned_a", int'(clk_out), 2);
        23: chk("p4_aligned_b", int'(clk_out), 3);
        31: chk("p6_ready_hi", int'(cfg_if.cfg_ready), 1);
        32: chk("p6_ready_lo", int'(cfg_if.cfg_ready), 0);
        34: begin
          chk("p6_rst_clk", int'(clk_out), 0);
          chk("p6_rst_rise", int'(rise_stb), 0);
          chk("p6_rst_fall", int'(fall_stb), 0);
          chk("p6_rst_ready_ch0", int'(cfg_if.cfg_ready), 1);
          cfg_if.cfg_ch = 1'b1;
          #1;
          chk("p6_rst_ready_ch1", int'(cfg_if.cfg_ready), 1);
          cfg_if.cfg_ch = 1'b0;
        end
        default: begin
          if (n >= 35 && n <= 40) chk("p6_restart_low", int'(clk_out), 0);
          else if (n >= 41 && n <= 46) chk("p6_restart_high", int'(clk_out), 1);
          else if (n == 47) chk("p6_restart_fall", int'(clk_out), 0);
        end
      endcase
    end

    repeat (3) @(posedge clk_12mhz);
    @(negedge clk_12mhz);
    chk("events_outstanding", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
